// File: rtl/cpu_bus_fabric.sv
// CPU-side memory-map fabric: range decode with per-slave mirroring, registered read return,
// open-bus latch and an optional page-copy DMA engine (enabled with `define CPU_BUS_DMA_EN).
module cpu_bus_fabric #(
  parameter int                          ADDR_W     = 16,
  parameter int                          DATA_W     = 8,
  parameter int                          NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE  = {16'h4020, 16'h4000, 16'h2000, 16'h0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_LIMIT = {16'hFFFF, 16'h401F, 16'h3FFF, 16'h1FFF},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK  = {16'hFFFF, 16'h001F, 16'h0007, 16'h07FF},
  parameter logic [ADDR_W-1:0]           DMA_REG    = 16'h4014,
  parameter logic [ADDR_W-1:0]           DMA_DST    = 16'h2004,
  parameter int                          DMA_LEN    = 256
) (
  input  logic                         CLK,
  input  logic                         RESET_n,
  input  logic [ADDR_W-1:0]            CPU_ADDR,
  input  logic [DATA_W-1:0]            CPU_DATA_OUT,
  input  logic                         CPU_RW_n,
  output logic                         CPU_ENABLE,
  output logic [DATA_W-1:0]            CPU_DATA_IN,
  output logic [ADDR_W-1:0]            SLV_ADDR,
  output logic [DATA_W-1:0]            SLV_WDATA,
  output logic [NUM_SLAVES-1:0]        SLV_WREN,
  output logic [NUM_SLAVES-1:0]        SLV_RDEN,
  input  logic [NUM_SLAVES*DATA_W-1:0] SLV_RDATA,
  output logic                         DMA_ACTIVE
);
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic [SEL_W-1:0]  dec_sel, sel_q, sel_d;
  logic              dec_hit, hit_q, hit_d;
  logic [DATA_W-1:0] open_bus_q, open_bus_d, ret_data, acc_wdata;
  logic [ADDR_W-1:0] acc_addr, dec_mask;
  logic              acc_rd, acc_wr, dma_act;

  assign ret_data = SLV_RDATA[int'(sel_q)*DATA_W +: DATA_W];

`ifdef CPU_BUS_DMA_EN
  localparam int IDX_W = ADDR_W - DATA_W;
  typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_RD, S_WR} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] page_q, page_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              parity_q, parity_d;

  // The bus master is muxed here: the CPU in IDLE, the DMA engine otherwise.
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    idx_d     = idx_q;
    parity_d  = !parity_q;
    dma_act   = (state_q != S_IDLE);
    acc_rd    = CPU_RW_n;
    acc_wr    = !CPU_RW_n;
    acc_addr  = CPU_ADDR;
    acc_wdata = CPU_DATA_OUT;
    case (state_q)
      S_IDLE: if (!CPU_RW_n && CPU_ADDR == DMA_REG) begin
        state_d = S_HALT;
        page_d  = CPU_DATA_OUT;
        idx_d   = '0;
      end
      S_HALT: begin
        acc_rd  = 1'b0;
        acc_wr  = 1'b0;
        state_d = parity_q ? S_ALIGN : S_RD;
      end
      S_ALIGN: begin
        acc_rd  = 1'b0;
        acc_wr  = 1'b0;
        state_d = S_RD;
      end
      S_RD: begin
        acc_rd   = 1'b1;
        acc_wr   = 1'b0;
        acc_addr = {page_q, idx_q};
        state_d  = S_WR;
      end
      S_WR: begin
        acc_rd    = 1'b0;
        acc_wr    = 1'b1;
        acc_addr  = DMA_DST;
        acc_wdata = hit_q ? ret_data : open_bus_q;
        idx_d     = idx_q + 1'b1;
        state_d   = (idx_q == IDX_W'(DMA_LEN - 1)) ? S_IDLE : S_RD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q  <= S_IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
    end
  end
`else
  always_comb begin
    dma_act   = 1'b0;
    acc_rd    = CPU_RW_n;
    acc_wr    = !CPU_RW_n;
    acc_addr  = CPU_ADDR;
    acc_wdata = CPU_DATA_OUT;
  end
`endif

  // Scan from the top index down so the lowest matching slave wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (acc_addr >= SLV_BASE[i*ADDR_W +: ADDR_W] && acc_addr <= SLV_LIMIT[i*ADDR_W +: ADDR_W]) begin
        dec_hit = 1'b1;
        dec_sel = SEL_W'(i);
      end
    end
  end

  assign dec_mask = SLV_MASK[int'(dec_sel)*ADDR_W +: ADDR_W];

  always_comb begin
    SLV_WREN = '0;
    SLV_RDEN = '0;
    SLV_ADDR = '0;
    if (RESET_n && dec_hit && (acc_rd || acc_wr)) begin
      SLV_ADDR          = acc_addr & dec_mask;
      SLV_WREN[dec_sel] = acc_wr;
      SLV_RDEN[dec_sel] = acc_rd;
    end
  end

  assign SLV_WDATA   = acc_wdata;
  assign CPU_ENABLE  = !dma_act;
  assign DMA_ACTIVE  = dma_act;
  assign CPU_DATA_IN = (hit_q && !dma_act) ? ret_data : open_bus_q;

  // A CPU write in the same cycle as a read return takes the open-bus latch.
  always_comb begin
    hit_d      = acc_rd && dec_hit;
    sel_d      = dec_sel;
    open_bus_d = open_bus_q;
    if (hit_q) open_bus_d = ret_data;
    if (acc_wr && !dma_act) open_bus_d = CPU_DATA_OUT;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      hit_q      <= 1'b0;
      sel_q      <= '0;
      open_bus_q <= '0;
    end else begin
      hit_q      <= hit_d;
      sel_q      <= sel_d;
      open_bus_q <= open_bus_d;
    end
  end
endmodule

// File: tb/tb_cpu_bus_fabric.sv
// Bench for cpu_bus_fabric: RAM-like slave models plus a map/memory/open-bus reference model.
module tb_cpu_bus_fabric;
  logic        CLK = 1'b0;
  logic        RESET_n;
  logic [15:0] CPU_ADDR;
  logic [7:0]  CPU_DATA_OUT;
  logic        CPU_RW_n;
  logic        CPU_ENABLE;
  logic [7:0]  CPU_DATA_IN;
  logic [15:0] SLV_ADDR;
  logic [7:0]  SLV_WDATA;
  logic [3:0]  SLV_WREN, SLV_RDEN;
  logic [31:0] SLV_RDATA;
  logic        DMA_ACTIVE;

  logic [7:0] rdat [4];
  bit   [7:0] smem [4][65536];
  bit         sok  [4][65536];
  bit   [7:0] mdl  [4][65536];
  bit         mok  [4][65536];
  bit   [7:0] salt;
  bit   [7:0] ob;
  bit         rp_hit;
  bit   [7:0] rp_data;
  int         pcnt = 0;
  int         vec, errs;

  assign SLV_RDATA = {rdat[3], rdat[2], rdat[1], rdat[0]};
  always #5 CLK = ~CLK;

  cpu_bus_fabric #(
    .SLV_LIMIT({16'hFFFF, 16'h4017, 16'h3FFF, 16'h1FFF})
  ) dut (
    .CLK(CLK), .RESET_n(RESET_n), .CPU_ADDR(CPU_ADDR), .CPU_DATA_OUT(CPU_DATA_OUT),
    .CPU_RW_n(CPU_RW_n), .CPU_ENABLE(CPU_ENABLE), .CPU_DATA_IN(CPU_DATA_IN),
    .SLV_ADDR(SLV_ADDR), .SLV_WDATA(SLV_WDATA), .SLV_WREN(SLV_WREN), .SLV_RDEN(SLV_RDEN),
    .SLV_RDATA(SLV_RDATA), .DMA_ACTIVE(DMA_ACTIVE)
  );

  function automatic bit [7:0] initv(input int s, input logic [15:0] a);
    return 8'((a * 29) ^ (a >> 7) ^ (s * 77)) ^ salt;
  endfunction

  // Test memory map: slave 2 stops at 4017 so 4018-401F is open bus.
  function automatic int smap(input logic [15:0] a, output logic [15:0] m);
    if (a <= 16'h1FFF) begin m = a % 16'h0800; return 0; end
    if (a <= 16'h3FFF) begin m = a % 16'h0008; return 1; end
    if (a <= 16'h4017) begin m = a % 16'h0020; return 2; end
    if (a >= 16'h4020) begin m = a; return 3; end
    m = 16'h0000;
    return -1;
  endfunction

  function automatic bit [7:0] mread(input int s, input logic [15:0] a);
    return mok[s][a] ? mdl[s][a] : initv(s, a);
  endfunction

  always @(posedge CLK) begin
    pcnt <= RESET_n ? pcnt + 1 : 0;
    for (int s = 0; s < 4; s++) begin
      if (SLV_WREN[s] === 1'b1) begin
        smem[s][SLV_ADDR] <= SLV_WDATA;
        sok[s][SLV_ADDR]  <= 1'b1;
      end
      if (SLV_RDEN[s] === 1'b1) rdat[s] <= sok[s][SLV_ADDR] ? smem[s][SLV_ADDR] : initv(s, SLV_ADDR);
    end
  end

  // One CPU bus cycle; checks the decode and the previous cycle's read return.
  task automatic access(input bit wr, input logic [15:0] a, input logic [7:0] d);
    int s;
    logic [15:0] m;
    logic [3:0] ew, er;
    logic [7:0] edin;
    s = smap(a, m);
    CPU_RW_n = !wr; CPU_ADDR = a; CPU_DATA_OUT = d;
    ew = (wr && s >= 0) ? 4'(1 << s) : 4'h0;
    er = (!wr && s >= 0) ? 4'(1 << s) : 4'h0;
    edin = rp_hit ? rp_data : ob;
    @(negedge CLK);
    vec++; if (SLV_WREN !== ew || SLV_RDEN !== er) begin
      errs++; $display("FAIL strobe @%h: wren=%b rden=%b want %b %b", a, SLV_WREN, SLV_RDEN, ew, er);
    end
    vec++; if (SLV_ADDR !== m) begin
      errs++; $display("FAIL slv_addr @%h: got %h want %h", a, SLV_ADDR, m);
    end
    if (wr && s >= 0) begin
      vec++; if (SLV_WDATA !== d) begin
        errs++; $display("FAIL wdata @%h: got %h want %h", a, SLV_WDATA, d);
      end
    end
    vec++; if (CPU_DATA_IN !== edin) begin
      errs++; $display("FAIL cpu_data_in @%h: got %h want %h", a, CPU_DATA_IN, edin);
    end
    vec++; if (CPU_ENABLE !== 1'b1 || DMA_ACTIVE !== 1'b0) begin
      errs++; $display("FAIL enable @%h: en=%b act=%b want 1 0", a, CPU_ENABLE, DMA_ACTIVE);
    end
    @(posedge CLK); #1;
    if (rp_hit) ob = rp_data;
    if (wr) ob = d;
    if (wr && s >= 0) begin mdl[s][m] = d; mok[s][m] = 1'b1; end
    rp_hit  = !wr && s >= 0;
    rp_data = (s >= 0) ? mread(s, m) : 8'h00;
  endtask

  task automatic test_reset;
    RESET_n = 1'b0; CPU_RW_n = 1'b0; CPU_ADDR = 16'h0100; CPU_DATA_OUT = 8'hEE;
    repeat (2) begin
      @(posedge CLK); @(negedge CLK);
      vec++; if (SLV_WREN !== 4'h0 || SLV_RDEN !== 4'h0) begin
        errs++; $display("FAIL reset_strobe: wren=%b rden=%b want 0 0", SLV_WREN, SLV_RDEN);
      end
      vec++; if (CPU_ENABLE !== 1'b1 || DMA_ACTIVE !== 1'b0 || CPU_DATA_IN !== 8'h00) begin
        errs++; $display("FAIL reset_out: en=%b act=%b din=%h want 1 0 00", CPU_ENABLE, DMA_ACTIVE, CPU_DATA_IN);
      end
    end
    @(posedge CLK); #1;
    RESET_n = 1'b1; CPU_RW_n = 1'b1; CPU_ADDR = 16'h0000;
    ob = 8'h00; rp_hit = 1'b0;
  endtask

  task automatic test_mirror;
    access(1'b1, 16'h0801, 8'h5A);
    access(1'b0, 16'h0001, 8'h00);
    access(1'b0, 16'h0000, 8'h00);
    vec++; if (rp_data !== mread(0, 16'h0000) || mread(0, 16'h0001) !== 8'h5A) begin
      errs++; $display("FAIL mirror_model: got %h want 5a", mread(0, 16'h0001));
    end
  endtask

  task automatic test_ppu_mirror;
    access(1'b1, 16'h2002, 8'h77);
    access(1'b0, 16'h3FFA, 8'h00);
    access(1'b0, 16'h0000, 8'h00);
  endtask

  task automatic test_open_bus;
    access(1'b1, 16'h4018, 8'hC3);
    access(1'b0, 16'h4018, 8'h00);
    access(1'b0, 16'h401F, 8'h00);
    access(1'b0, 16'h0000, 8'h00);
  endtask

  task automatic test_random;
    logic [15:0] a;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(3))
        0: a = 16'($urandom_range(16'h1FFF));
        1: a = 16'h2000 + 16'($urandom_range(16'h1FFF));
        2: a = 16'h4000 + 16'($urandom_range(31));
        default: a = 16'($urandom);
      endcase
`ifdef CPU_BUS_DMA_EN
      if (a == 16'h4014) a = 16'h4015;
`endif
      access(1'($urandom), a, 8'($urandom));
    end
    access(1'b0, 16'h0000, 8'h00);
  endtask

`ifdef CPU_BUS_DMA_EN
  task automatic run_dma(input logic [7:0] page, input bit odd, input int abort_idx);
    int n, k, i, s, ds;
    bit fin, abort_now;
    logic [15:0] m, dm;
    logic [3:0] ew, er;
    logic [15:0] ea;
    logic [7:0] ed;
    while (pcnt[0] != !odd) access(1'b0, 16'h0000, 8'h00);
    access(1'b1, 16'h4014, page);
    ds = smap(16'h2004, dm);
    n = 0; fin = 1'b0; abort_now = 1'b0;
    while (!fin) begin
      @(negedge CLK);
      if (CPU_ENABLE === 1'b1 || n >= 600) fin = 1'b1;
      else begin
        k = n - 1 - int'(odd);
        i = k / 2;
        ew = 4'h0; er = 4'h0; ea = 16'h0000; ed = 8'h00; s = -1; m = 16'h0000;
        if (k >= 0) begin
          s = smap({page, 8'(i)}, m);
          if (k % 2 == 0) begin
            er = (s >= 0) ? 4'(1 << s) : 4'h0; ea = m;
          end else begin
            ew = 4'(1 << ds); ea = dm; ed = (s >= 0) ? mread(s, m) : ob;
          end
        end
        vec++; if (SLV_WREN !== ew || SLV_RDEN !== er) begin
          errs++; $display("FAIL dma_strobe cyc %0d: wren=%b rden=%b want %b %b", n, SLV_WREN, SLV_RDEN, ew, er);
        end
        if (k >= 0) begin
          vec++; if (SLV_ADDR !== ea) begin
            errs++; $display("FAIL dma_addr cyc %0d: got %h want %h", n, SLV_ADDR, ea);
          end
        end
        if (k >= 0 && k % 2 == 1) begin
          vec++; if (SLV_WDATA !== ed) begin
            errs++; $display("FAIL dma_wdata idx %0d: got %h want %h", i, SLV_WDATA, ed);
          end
        end
        vec++; if (DMA_ACTIVE !== 1'b1) begin
          errs++; $display("FAIL dma_active cyc %0d: got %b want 1", n, DMA_ACTIVE);
        end
        abort_now = (abort_idx >= 0 && k >= 0 && k % 2 == 0 && i == abort_idx);
        if (abort_now || (k >= 0 && k % 2 == 1 && i == 255)) begin
          CPU_RW_n = 1'b1; CPU_ADDR = 16'h0000; CPU_DATA_OUT = 8'h00;
        end else begin
          CPU_RW_n = 1'($urandom); CPU_ADDR = 16'($urandom); CPU_DATA_OUT = 8'($urandom);
        end
        if (abort_now) RESET_n = 1'b0;
        @(posedge CLK); #1;
        if (k >= 0 && k % 2 == 1) begin
          mdl[ds][dm] = ed; mok[ds][dm] = 1'b1; ob = ed;
        end
        n++;
        if (abort_now) fin = 1'b1;
      end
    end
    if (abort_now) begin
      vec++; if (CPU_ENABLE !== 1'b1 || DMA_ACTIVE !== 1'b0) begin
        errs++; $display("FAIL abort_out: en=%b act=%b want 1 0", CPU_ENABLE, DMA_ACTIVE);
      end
      vec++; if (SLV_WREN !== 4'h0 || SLV_RDEN !== 4'h0) begin
        errs++; $display("FAIL abort_strobe: wren=%b rden=%b want 0 0", SLV_WREN, SLV_RDEN);
      end
      @(posedge CLK); #1;
      RESET_n = 1'b1; ob = 8'h00; rp_hit = 1'b0;
    end else begin
      vec++; if (n != 513 + int'(odd)) begin
        errs++; $display("FAIL dma_stall: got %0d cycles want %0d", n, 513 + int'(odd));
      end
      vec++; if (SLV_RDEN !== 4'h1 || DMA_ACTIVE !== 1'b0) begin
        errs++; $display("FAIL dma_exit: rden=%b act=%b want 0001 0", SLV_RDEN, DMA_ACTIVE);
      end
      @(posedge CLK); #1;
      rp_hit = 1'b1; rp_data = mread(0, 16'h0000);
    end
  endtask

  task automatic test_dma_even;
    run_dma(8'h02, 1'b0, -1);
    access(1'b0, 16'h2004, 8'h00);
    access(1'b0, 16'h0000, 8'h00);
  endtask

  task automatic test_dma_odd;
    access(1'b1, 16'h0345, 8'h9C);
    run_dma(8'h03, 1'b1, -1);
    access(1'b0, 16'h3FFC, 8'h00);
    access(1'b0, 16'h0000, 8'h00);
  endtask

  task automatic test_reset_mid_dma;
    access(1'b1, 16'h0340, 8'h11);
    run_dma(8'h03, 1'($urandom), 8'h40);
    access(1'b0, 16'h0000, 8'h00);
    access(1'b0, 16'h2004, 8'h00);
    access(1'b0, 16'h0000, 8'h00);
  endtask
`else
  task automatic test_dma_reg_plain;
    access(1'b1, 16'h4014, 8'h02);
    access(1'b0, 16'h4014, 8'h00);
    access(1'b0, 16'h0000, 8'h00);
  endtask
`endif

  initial begin
    salt = 8'($urandom);
    vec = 0; errs = 0; ob = 8'h00; rp_hit = 1'b0; rp_data = 8'h00;
    RESET_n = 1'b0; CPU_RW_n = 1'b1; CPU_ADDR = 16'h0000; CPU_DATA_OUT = 8'h00;
    test_reset;
    test_mirror;
    test_ppu_mirror;
    test_open_bus;
    test_random;
`ifdef CPU_BUS_DMA_EN
    test_dma_even;
    test_dma_odd;
    test_reset_mid_dma;
`else
    test_dma_reg_plain;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
